// File: rtl/multicycle_controller_pkg.sv
// Shared types for the multicycle controller: FSM states, opcodes and
// datapath select encodings, plus the Moore output decode.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEMADR    = 4'd2,
        MEMREAD   = 4'd3,
        MEMWRITE  = 4'd4,
        MEMWB     = 4'd5,
        EXEC_R    = 4'd6,
        LUI       = 4'd7,
        ALUWB     = 4'd8,
        BRANCH    = 4'd9,
        JAL       = 4'd10,
        JALR      = 4'd11,
        JALR_LINK = 4'd12,
        FAULT     = 4'd13
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_t;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_SUB    = 2'b01,
        ALU_FUNCT  = 2'b10,
        ALU_PASS_B = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        SRC_A_PC     = 2'b00,
        SRC_A_OLD_PC = 2'b01,
        SRC_A_RS1    = 2'b10
    } alu_src_a_t;

    typedef enum logic [1:0] {
        SRC_B_RS2  = 2'b00,
        SRC_B_IMM  = 2'b01,
        SRC_B_FOUR = 2'b10
    } alu_src_b_t;

    typedef enum logic [1:0] {
        RES_ALU_OUT    = 2'b00,
        RES_READ_DATA  = 2'b01,
        RES_ALU_RESULT = 2'b10
    } result_src_t;

    typedef struct packed {
        logic        mem_req;
        logic        adr_src;
        logic        reg_write;
        logic        pc_write;
        alu_src_a_t  alu_src_a;
        alu_src_b_t  alu_src_b;
        result_src_t result_src;
        alu_op_t     alu_op;
        logic        err;
    } ctrl_t;

    // Input-independent outputs of each state; anything not set stays 0.
    function automatic ctrl_t decode_state(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_req    = 1'b1;
                c.alu_src_b  = SRC_B_FOUR;
                c.result_src = RES_ALU_RESULT;
            end
            DECODE: begin
                c.alu_src_a = SRC_A_OLD_PC;
                c.alu_src_b = SRC_B_IMM;
            end
            MEMADR: begin
                c.alu_src_a = SRC_A_RS1;
                c.alu_src_b = SRC_B_IMM;
            end
            MEMREAD, MEMWRITE: begin
                c.mem_req = 1'b1;
                c.adr_src = 1'b1;
            end
            MEMWB: begin
                c.result_src = RES_READ_DATA;
                c.reg_write  = 1'b1;
            end
            EXEC_R: begin
                c.alu_src_a = SRC_A_RS1;
                c.alu_op    = ALU_FUNCT;
            end
            LUI: begin
                c.alu_src_b = SRC_B_IMM;
                c.alu_op    = ALU_PASS_B;
            end
            ALUWB: c.reg_write = 1'b1;
            BRANCH: begin
                c.alu_src_a = SRC_A_RS1;
                c.alu_op    = ALU_SUB;
            end
            JAL, JALR_LINK: begin
                c.alu_src_a = SRC_A_OLD_PC;
                c.alu_src_b = SRC_B_FOUR;
                c.pc_write  = 1'b1;
            end
            JALR: begin
                c.alu_src_a = SRC_A_RS1;
                c.alu_src_b = SRC_B_IMM;
            end
            FAULT:   c.err = 1'b1;
            default: c.err = 1'b1;
        endcase
        return c;
    endfunction

    function automatic logic is_wait_state(state_t s);
        return (s == FETCH) || (s == MEMREAD) || (s == MEMWRITE);
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Unified-memory handshake between the controller (master) and memory (slave).
interface multicycle_controller_if;
    logic mem_req_o;
    logic adr_src_o;
    logic mem_write_o;
    logic mem_ready_i;

    modport master (
        output mem_req_o,
        output adr_src_o,
        output mem_write_o,
        input  mem_ready_i
    );

    modport slave (
        input  mem_req_o,
        input  adr_src_o,
        input  mem_write_o,
        output mem_ready_i
    );
endinterface

// File: rtl/multicycle_controller_wait_timer.sv
// Counts consecutive not-ready cycles in a memory state and flags expiry
// on the last permitted cycle so the FSM can fault instead of advancing.
module wait_timer #(
    parameter int WAIT_TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clear,
    input  logic ready,
    output logic expired
);
    localparam int CW = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(WAIT_TIMEOUT - 1);

    logic [CW-1:0] count;

    // A completed access restarts the count, so each new wait state begins at 0.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count <= '0;
        end else if (clear || ready) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign expired = !clear && !ready && (count == LAST);
endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V style control FSM: sequences fetch, decode, execute,
// memory and writeback, with a memory-wait timeout into a sticky fault state.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [6:0]              op_i,
    input  logic                    zero_i,
    multicycle_controller_if.master mem,
    output logic                    ir_write_o,
    output logic                    pc_write_o,
    output logic                    reg_write_o,
    output logic [1:0]              alu_src_a_o,
    output logic [1:0]              alu_src_b_o,
    output logic [1:0]              result_src_o,
    output logic [2:0]              imm_src_o,
    output logic [1:0]              alu_op_o,
    output logic                    err_o,
    output logic [3:0]              state_o
);
    state_t   state;
    state_t   next_state;
    ctrl_t    ctrl;
    imm_src_t imm_src;
    logic     timer_clear;
    logic     expired;
    logic     ready;

    assign ready       = mem.mem_ready_i;
    assign timer_clear = !is_wait_state(state);

    wait_timer #(
        .WAIT_TIMEOUT(WAIT_TIMEOUT)
    ) u_wait_timer (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clear   (timer_clear),
        .ready   (ready),
        .expired (expired)
    );

    always_comb begin
        next_state = state;
        case (state)
            FETCH: begin
                if (expired)    next_state = FAULT;
                else if (ready) next_state = DECODE;
            end
            DECODE: begin
                case (op_i)
                    OP_LOAD, OP_STORE: next_state = MEMADR;
                    OP_RTYPE:          next_state = EXEC_R;
                    OP_BRANCH:         next_state = BRANCH;
                    OP_JAL:            next_state = JAL;
                    OP_JALR:           next_state = JALR;
                    OP_LUI:            next_state = LUI;
                    default:           next_state = FAULT;
                endcase
            end
            MEMADR:    next_state = (op_i == OP_LOAD) ? MEMREAD : MEMWRITE;
            MEMREAD: begin
                if (expired)    next_state = FAULT;
                else if (ready) next_state = MEMWB;
            end
            MEMWRITE: begin
                if (expired)    next_state = FAULT;
                else if (ready) next_state = FETCH;
            end
            MEMWB:     next_state = FETCH;
            EXEC_R:    next_state = ALUWB;
            LUI:       next_state = ALUWB;
            ALUWB:     next_state = FETCH;
            BRANCH:    next_state = FETCH;
            JAL:       next_state = ALUWB;
            JALR:      next_state = JALR_LINK;
            JALR_LINK: next_state = ALUWB;
            FAULT:     next_state = FAULT;
            default:   next_state = FAULT;
        endcase
    end

    // Moore outputs are registered alongside the state they belong to.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= FETCH;
            ctrl  <= decode_state(FETCH);
        end else begin
            state <= next_state;
            ctrl  <= decode_state(next_state);
        end
    end

    // Immediate type follows the opcode, which only settles once the IR is loaded.
    always_comb begin
        imm_src = IMM_I;
        case (state)
            DECODE:  imm_src = (op_i == OP_JAL) ? IMM_J : IMM_B;
            MEMADR:  imm_src = (op_i == OP_STORE) ? IMM_S : IMM_I;
            LUI:     imm_src = IMM_U;
            default: imm_src = IMM_I;
        endcase
    end

    assign ir_write_o      = (state == FETCH) && ready;
    assign pc_write_o      = ctrl.pc_write || ir_write_o || ((state == BRANCH) && zero_i);
    assign mem.mem_write_o = (state == MEMWRITE) && ready;
    assign mem.mem_req_o   = ctrl.mem_req;
    assign mem.adr_src_o   = ctrl.adr_src;
    assign reg_write_o     = ctrl.reg_write;
    assign alu_src_a_o     = ctrl.alu_src_a;
    assign alu_src_b_o     = ctrl.alu_src_b;
    assign result_src_o    = ctrl.result_src;
    assign alu_op_o        = ctrl.alu_op;
    assign imm_src_o       = imm_src;
    assign err_o           = ctrl.err;
    assign state_o         = state;
endmodule
